// File: rtl/atm_pkg.sv
// Shared ATM definitions: keypad codes, PIN sizing and the state encodings of
// the PIN entry stage and the downstream session controller.
package atm_pkg;

   localparam int DIGIT_W        = 4;
   localparam int PIN_DIGITS_DEF = 4;
   localparam int PIN_W          = DIGIT_W * PIN_DIGITS_DEF;

   localparam logic [3:0] KEY_CLEAR  = 4'hA;
   localparam logic [3:0] KEY_ENTER  = 4'hB;
   localparam logic [3:0] KEY_CANCEL = 4'hC;

   typedef enum logic [2:0] {
      PE_IDLE,
      PE_COLLECT,
      PE_COMPARE,
      PE_REPORT,
      PE_WAIT_REMOVE
   } pe_state_t;

   typedef enum logic [2:0] {
      ATM_IDLE,
      ATM_READ_CARD,
      ATM_PIN,
      ATM_MENU,
      ATM_DISPENSE,
      ATM_EJECT
   } atm_state_t;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

endpackage

// File: rtl/pin_entry_unit_if.sv
// Keypad/card inputs and verdict/status outputs of the PIN entry stage.
interface pin_entry_unit_if;
   logic       card_inserted;
   logic       key_valid;
   logic [3:0] key_code;
   logic       pin_entered;
   logic       pin_correct;
   logic       pin_retry;
   logic [3:0] digit_count;
   logic [1:0] attempts_left;
   logic       locked;
   logic       busy;

   modport master (
      output card_inserted, key_valid, key_code,
      input  pin_entered, pin_correct, pin_retry, digit_count, attempts_left, locked, busy
   );

   modport slave (
      input  card_inserted, key_valid, key_code,
      output pin_entered, pin_correct, pin_retry, digit_count, attempts_left, locked, busy
   );
endinterface

// File: rtl/pin_digit_buffer.sv
// BCD digit shift register with fill count; first digit ends up in the top nibble.
module pin_digit_buffer
   import atm_pkg::*;
#(
   parameter int PIN_DIGITS = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          clear,
   input  logic                          load,
   input  logic [DIGIT_W-1:0]            digit,
   output logic [DIGIT_W*PIN_DIGITS-1:0] pin,
   output logic [3:0]                    count,
   output logic                          full
);

   localparam int W = DIGIT_W * PIN_DIGITS;

   assign full = (count == 4'(PIN_DIGITS));

   // clear wins over load; loads past a full buffer are dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pin   <= '0;
         count <= '0;
      end else if (clear) begin
         pin   <= '0;
         count <= '0;
      end else if (load && !full) begin
         pin   <= (pin << DIGIT_W) | W'(digit);
         count <= count + 4'd1;
      end
   end

endmodule

// File: rtl/pin_entry_unit.sv
// Per-session PIN collection, comparison against STORED_PIN, retry accounting
// and sticky lockout; produces one verdict pulse per card session.
module pin_entry_unit
   import atm_pkg::*;
#(
   parameter int                            PIN_DIGITS     = 4,
   parameter int                            MAX_TRIES      = 3,
   parameter int                            TIMEOUT_CYCLES = 1000,
   parameter logic [DIGIT_W*PIN_DIGITS-1:0] STORED_PIN     = 16'h1234
) (
   input  logic             clk,
   input  logic             reset_n,
   pin_entry_unit_if.slave  bus
);

   localparam int         TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] MAX_A = 2'(MAX_TRIES);

   pe_state_t                     state;
   logic [TW-1:0]                 timer;
   logic [1:0]                    att;
   logic                          pin_entered_r, pin_correct_r, pin_retry_r, locked_r, busy_r;
   logic                          buf_clr, buf_load, buf_full;
   logic [DIGIT_W*PIN_DIGITS-1:0] buf_pin;
   logic [3:0]                    buf_cnt;
   logic                          card, kv, match;
   logic [3:0]                    key;

   assign card  = bus.card_inserted;
   assign kv    = bus.key_valid;
   assign key   = bus.key_code;
   assign match = (buf_pin == STORED_PIN);

   always_comb begin
      buf_clr  = 1'b0;
      buf_load = 1'b0;
      case (state)
         PE_IDLE:    buf_clr = card;
         PE_COLLECT: begin
            buf_clr  = !card || (kv && key == KEY_CLEAR);
            buf_load = card && kv && is_digit(key);
         end
         PE_COMPARE: buf_clr = !card || (!match && att > 2'd1);
         default:    ;
      endcase
   end

   pin_digit_buffer #(.PIN_DIGITS(PIN_DIGITS)) u_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (buf_clr),
      .load    (buf_load),
      .digit   (key),
      .pin     (buf_pin),
      .count   (buf_cnt),
      .full    (buf_full)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= PE_IDLE;
         timer         <= '0;
         att           <= MAX_A;
         pin_entered_r <= 1'b0;
         pin_correct_r <= 1'b0;
         pin_retry_r   <= 1'b0;
         locked_r      <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         pin_entered_r <= 1'b0;
         pin_retry_r   <= 1'b0;
         case (state)
            PE_IDLE: begin
               if (card) begin
                  if (locked_r) begin
                     state         <= PE_REPORT;
                     pin_entered_r <= 1'b1;
                     pin_correct_r <= 1'b0;
                  end else begin
                     state         <= PE_COLLECT;
                     timer         <= '0;
                     att           <= MAX_A;
                     pin_correct_r <= 1'b0;
                     busy_r        <= 1'b1;
                  end
               end
            end
            PE_COLLECT: begin
               if (!card) begin
                  state  <= PE_IDLE;
                  busy_r <= 1'b0;
               end else if (kv) begin
                  timer <= '0;
                  if (key == KEY_CANCEL) begin
                     state         <= PE_REPORT;
                     pin_entered_r <= 1'b1;
                     pin_correct_r <= 1'b0;
                     busy_r        <= 1'b0;
                  end else if (key == KEY_ENTER && buf_full) begin
                     state <= PE_COMPARE;
                  end
               end else if (timer == TMAX) begin
                  state         <= PE_REPORT;
                  pin_entered_r <= 1'b1;
                  pin_correct_r <= 1'b0;
                  busy_r        <= 1'b0;
               end else begin
                  // leaving at TMAX keeps the timer from ever wrapping
                  timer <= timer + 1'b1;
               end
            end
            PE_COMPARE: begin
               if (!card) begin
                  state  <= PE_IDLE;
                  busy_r <= 1'b0;
               end else if (match) begin
                  state         <= PE_REPORT;
                  pin_entered_r <= 1'b1;
                  pin_correct_r <= 1'b1;
                  busy_r        <= 1'b0;
               end else if (att > 2'd1) begin
                  state       <= PE_COLLECT;
                  att         <= att - 2'd1;
                  pin_retry_r <= 1'b1;
                  timer       <= '0;
               end else begin
                  state         <= PE_REPORT;
                  att           <= 2'd0;
                  locked_r      <= 1'b1;
                  pin_entered_r <= 1'b1;
                  pin_correct_r <= 1'b0;
                  busy_r        <= 1'b0;
               end
            end
            PE_REPORT:      state <= PE_WAIT_REMOVE;
            PE_WAIT_REMOVE: if (!card) state <= PE_IDLE;
            default:        state <= PE_IDLE;
         endcase
      end
   end

   assign bus.pin_entered   = pin_entered_r;
   assign bus.pin_correct   = pin_correct_r;
   assign bus.pin_retry     = pin_retry_r;
   assign bus.digit_count   = buf_cnt;
   assign bus.attempts_left = att;
   assign bus.locked        = locked_r;
   assign bus.busy          = busy_r;

endmodule

// File: tb/tb_pin_entry_unit.sv
// Directed plus randomized keypad sessions checked against a digit-queue model
// of the PIN entry rules.
module tb_pin_entry_unit;
   import atm_pkg::*;

   localparam int          PD = 4;
   localparam int          MT = 3;
   localparam int          TO = 16;
   localparam logic [15:0] SP = 16'h1234;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   pin_entry_unit_if bus();

   pin_entry_unit #(.PIN_DIGITS(PD), .MAX_TRIES(MT), .TIMEOUT_CYCLES(TO), .STORED_PIN(SP)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int passed = 0;
   int total  = 0;
   int ent_cnt = 0;
   int retry_cnt = 0;

   always @(negedge clk) begin
      if (bus.pin_entered === 1'b1) ent_cnt++;
      if (bus.pin_retry === 1'b1) retry_cnt++;
   end

   // reference model
   int m_dig[$];
   int m_att = MT;
   bit m_lock = 0, m_sess = 0, m_verdict = 0;
   int exp_ent = 0, exp_retry = 0;

   function automatic int stored_digit(input int i);
      return int'((SP >> (4 * (PD - 1 - i))) & 16'hF);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic m_end(input bit ok);
      exp_ent++;
      m_verdict = ok;
      m_sess = 0;
   endtask

   task automatic model_key(input int k);
      int v;
      if (!m_sess) return;
      if (k <= 9) begin
         if (m_dig.size() < PD) m_dig.push_back(k);
      end else if (k == 10) begin
         m_dig.delete();
      end else if (k == 11 && m_dig.size() == PD) begin
         v = 0;
         foreach (m_dig[i]) v = v * 16 + m_dig[i];
         if (v == int'(SP)) m_end(1);
         else if (m_att > 1) begin
            m_att--;
            exp_retry++;
            m_dig.delete();
         end else begin
            m_att = 0;
            m_lock = 1;
            m_end(0);
         end
      end else if (k == 12) begin
         m_end(0);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ":entered_cnt"}, ent_cnt, exp_ent);
      chk({tag, ":retry_cnt"}, retry_cnt, exp_retry);
      chk({tag, ":pin_correct"}, 32'(bus.pin_correct), 32'(m_verdict));
      chk({tag, ":locked"}, 32'(bus.locked), 32'(m_lock));
      chk({tag, ":attempts"}, 32'(bus.attempts_left), m_att);
      chk({tag, ":busy"}, 32'(bus.busy), 32'(m_sess));
      if (m_sess) chk({tag, ":digit_count"}, 32'(bus.digit_count), m_dig.size());
   endtask

   task automatic press(input int k, input string tag);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = 4'(k);
      @(negedge clk);
      bus.key_valid = 1'b0;
      model_key(k);
      repeat (2) @(negedge clk);
      check_state(tag);
   endtask

   task automatic insert(input string tag);
      @(negedge clk);
      bus.card_inserted = 1'b1;
      if (m_lock) begin
         exp_ent++;
         m_verdict = 0;
      end else begin
         m_sess = 1;
         m_dig.delete();
         m_att = MT;
         m_verdict = 0;
      end
      repeat (3) @(negedge clk);
      check_state(tag);
   endtask

   task automatic remove(input string tag);
      bit was = m_sess;
      @(negedge clk);
      bus.card_inserted = 1'b0;
      m_sess = 0;
      m_dig.delete();
      repeat (2) @(negedge clk);
      check_state(tag);
      if (was) chk({tag, ":cleared"}, 32'(bus.digit_count), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ":entered"}, 32'(bus.pin_entered), 0);
      chk({tag, ":correct"}, 32'(bus.pin_correct), 0);
      chk({tag, ":retry"}, 32'(bus.pin_retry), 0);
      chk({tag, ":locked"}, 32'(bus.locked), 0);
      chk({tag, ":busy"}, 32'(bus.busy), 0);
      chk({tag, ":digits"}, 32'(bus.digit_count), 0);
      chk({tag, ":attempts"}, 32'(bus.attempts_left), MT);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset_vals(tag);
      bus.card_inserted = 1'b0;
      bus.key_valid = 1'b0;
      m_dig.delete(); m_att = MT; m_lock = 0; m_sess = 0; m_verdict = 0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic enter_pin(input int d0, input int d1, input int d2, input int d3, input string tag);
      press(d0, tag); press(d1, tag); press(d2, tag); press(d3, tag);
      press(11, tag);
   endtask

   initial begin
      int seen, r, k;
      bus.card_inserted = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_code = 4'h0;

      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      reset_n = 1'b1;
      @(negedge clk);

      // correct PIN with exact verdict latency
      insert("s1_ins");
      press(1, "s1"); press(2, "s1"); press(3, "s1"); press(4, "s1");
      @(negedge clk);
      bus.key_valid = 1'b1; bus.key_code = KEY_ENTER;
      @(negedge clk);
      bus.key_valid = 1'b0;
      model_key(11);
      chk("lat_compare_cycle", 32'(bus.pin_entered), 0);
      @(negedge clk);
      chk("lat_verdict_cycle", 32'(bus.pin_entered), 1);
      chk("lat_verdict_value", 32'(bus.pin_correct), 1);
      @(negedge clk);
      chk("lat_pulse_width", 32'(bus.pin_entered), 0);
      check_state("s1_end");
      press(5, "s1_key_in_wait");
      remove("s1_rm");

      // one retry then success
      insert("s2_ins");
      enter_pin(1, 1, 1, 1, "s2_wrong");
      enter_pin(1, 2, 3, 4, "s2_right");
      remove("s2_rm");

      // lockout, then locked reinsertion fails at once
      insert("s3_ins");
      enter_pin(9, 9, 9, 9, "s3_w1");
      enter_pin(0, 0, 0, 0, "s3_w2");
      enter_pin(4, 3, 2, 1, "s3_w3");
      remove("s3_rm");
      insert("s3_locked_ins");
      remove("s3_locked_rm");
      do_reset("s3_reset");
      check_state("s3_unlocked");

      // CLEAR and overflow digit; short ENTER; CANCEL
      insert("s4_ins");
      press(1, "s4"); press(2, "s4"); press(10, "s4_clr");
      press(1, "s4"); press(2, "s4"); press(3, "s4"); press(4, "s4"); press(5, "s4_over");
      press(11, "s4_enter");
      remove("s4_rm");
      insert("s5_ins");
      press(1, "s5"); press(2, "s5"); press(3, "s5");
      press(11, "s5_short_enter");
      press(14, "s5_ignored_code");
      press(12, "s5_cancel");
      remove("s5_rm");

      // inactivity timeout
      @(negedge clk);
      bus.card_inserted = 1'b1;
      m_sess = 1; m_dig.delete(); m_att = MT; m_verdict = 0;
      seen = 0;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         if (seen == 0 && bus.pin_entered === 1'b1) seen = i;
      end
      chk("timeout_cycle", seen, 17);
      m_end(0);
      check_state("timeout");
      remove("timeout_rm");

      // removal mid-entry, then async reset mid-entry
      insert("s6_ins");
      press(1, "s6"); press(2, "s6");
      remove("s6_rm");
      insert("s7_ins");
      press(5, "s7"); press(6, "s7");
      do_reset("s7_async_reset");
      check_state("s7_after");

      // randomized sessions
      for (int s = 0; s < 40; s++) begin
         insert("rnd_ins");
         for (int j = 0; j < 25 && m_sess; j++) begin
            r = $urandom_range(99);
            if (r >= 95) begin
               remove("rnd_pull");
               break;
            end
            if (r < 45)      k = stored_digit(m_dig.size() % PD);
            else if (r < 60) k = $urandom_range(9);
            else if (r < 75) k = 11;
            else if (r < 82) k = 10;
            else if (r < 85) k = 12;
            else             k = $urandom_range(15, 13);
            press(k, "rnd_key");
         end
         if (bus.card_inserted) remove("rnd_rm");
         if (m_lock) begin
            insert("rnd_locked_ins");
            remove("rnd_locked_rm");
            do_reset("rnd_reset");
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pin_entry_unit.md
Name: pin_entry_unit

Overview:
- Keypad PIN-collection and verification stage.
- Sits directly upstream of the ATM session controller and drives that controller's pin_entered / pin_correct inputs.
- Per card session it collects decimal digits, compares them with a stored PIN, and allows MAX_TRIES attempts.
- It reports one final verdict per session and keeps a sticky lockout flag.

Parameters:
PIN_DIGITS, 4, number of BCD digits in a PIN (1..8)
MAX_TRIES, 3, wrong attempts allowed before failure is reported (1..3)
TIMEOUT_CYCLES, 1000, idle cycles allowed in COLLECT before automatic failure
STORED_PIN, 16'h1234, reference PIN, BCD, first-entered digit in the most significant nibble (width 4*PIN_DIGITS)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
card_inserted  input  1  level; card present in slot
key_valid  input  1  one-cycle strobe qualifying key_code
key_code  input  4  0-9 digit, 4'hA CLEAR, 4'hB ENTER, 4'hC CANCEL; any other code is ignored
pin_entered  output  1  one-cycle pulse: session verdict valid
pin_correct  output  1  verdict; valid with pin_entered; held until the next session starts
pin_retry  output  1  one-cycle pulse: wrong PIN, another attempt is allowed
digit_count  output  4  digits currently buffered (for the display)
attempts_left  output  2  remaining attempts in this session
locked  output  1  sticky lockout flag
busy  output  1  high in COLLECT and COMPARE

Behaviour:
- Only one clock domain is used. Reset is asynchronous and active-low.
- Reset values:
  - state IDLE; digit buffer 0; digit_count 0; attempts_left = MAX_TRIES
  - pin_entered, pin_correct, pin_retry, locked, busy all 0
  - timeout counter 0
- State encoding (held in package): IDLE, COLLECT, COMPARE, REPORT, WAIT_REMOVE.
- IDLE: when card_inserted = 1:
  - if locked, go to REPORT with verdict fail;
  - otherwise go to COLLECT and clear buffer, count and timer; set attempts_left = MAX_TRIES.
- COLLECT:
  - Digit with digit_count < PIN_DIGITS: shift the buffer left 4 bits, load the digit into the low nibble, increment digit_count. Digits beyond PIN_DIGITS are ignored.
  - CLEAR: buffer and count go to 0.
  - ENTER with digit_count == PIN_DIGITS: go to COMPARE. ENTER with fewer digits is ignored.
  - CANCEL: REPORT with verdict fail.
  - Any accepted key (including ignored codes) resets the timer.
  - Timer reaching TIMEOUT_CYCLES-1 with no key: REPORT with verdict fail.
- COMPARE (1 cycle), buffer == STORED_PIN:
  - match: REPORT with verdict pass.
  - mismatch with attempts_left > 1: decrement attempts_left, pulse pin_retry in this cycle, clear buffer and count, return to COLLECT.
  - mismatch with attempts_left == 1: attempts_left becomes 0, set locked, REPORT with verdict fail.
- REPORT (1 cycle): pin_entered = 1 and pin_correct = verdict. Next state is WAIT_REMOVE.
- WAIT_REMOVE: hold pin_correct. Return to IDLE when card_inserted = 0.
- Latency: ENTER accepted in cycle N -> COMPARE in cycle N+1 -> pin_entered high in cycle N+2.
- Card removal in COLLECT or COMPARE: go to IDLE and clear buffer. No pin_entered or pin_retry pulse is produced.
  - Removal has priority over a simultaneous key or the timeout.
- key_valid is ignored outside COLLECT.
- pin_correct clears on entry to COLLECT.
- locked clears only on reset_n.
- reset_n asserted in any state forces all outputs to their reset values immediately.
- Timer width is clog2(TIMEOUT_CYCLES). Timer saturates and does not wrap.

Decomposition:
- Shared package atm_pkg holds:
  - key code constants KEY_CLEAR, KEY_ENTER, KEY_CANCEL
  - the pin_entry_unit state encoding
  - a PIN width localparam
  - the session controller's state encoding, so both stages share one definition
- One sub-module: pin_digit_buffer. It is the shift register plus count, with load/clear/full controls, parameterised by PIN_DIGITS.

Test Plan:
- Reset, card_inserted=1, keys 1,2,3,4,ENTER -> pin_entered pulse 2 cycles after ENTER with pin_correct=1, attempts_left=3, locked=0.
- Keys 1,1,1,1,ENTER -> pin_retry pulse, attempts_left=2, no pin_entered. Then 1,2,3,4,ENTER -> pin_entered with pin_correct=1.
- Three wrong PINs -> third gives pin_entered=1, pin_correct=0, locked=1, attempts_left=0. Remove and reinsert card -> immediate fail pulse with no keys entered.
- Keys 1,2,CLEAR,1,2,3,4,5,ENTER -> correct (5 ignored). Separately, 1,2,3,ENTER -> no transition, digit_count stays 3.
- TIMEOUT_CYCLES=16, no keys for 16 cycles -> fail pulse. CANCEL mid-entry -> fail pulse.
- Card removed after two digits -> IDLE with no pulse. reset_n=0 mid-COLLECT -> all outputs at reset values asynchronously, locked cleared.
